// File: rtl/quad_comm_pkg.sv
// Shared types and helpers for the quad command link: receiver states, frame size, checksum.
// Frame length depends on UART_CMD_CHKSUM_EN (4 bytes with checksum, 3 without).
package quad_comm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        CHK
    } rcv_state_t;

`ifdef UART_CMD_CHKSUM_EN
    localparam int FRAME_BYTES = 4;
`else
    localparam int FRAME_BYTES = 3;
`endif

    // One's complement of the byte sum of cmd and both data bytes
    function automatic logic [7:0] frame_chksum(input logic [7:0] c, input logic [15:0] d);
        logic [7:0] sum;
        sum = c + d[15:8] + d[7:0];
        return ~sum;
    endfunction

endpackage

// File: rtl/uart_cmd_rcv_if.sv
// Decoder-facing handshake of the command receiver: received frame, flags and response request.
// master = flight-control command decoder, slave = uart_cmd_rcv.
interface uart_cmd_rcv_if;
    logic        clr_cmd_rdy;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic        frame_err;

    modport master (
        output clr_cmd_rdy, resp, send_resp,
        input  cmd_rdy, cmd, data, resp_sent, frame_err
    );

    modport slave (
        input  clr_cmd_rdy, resp, send_resp,
        output cmd_rdy, cmd, data, resp_sent, frame_err
    );
endinterface

// File: rtl/uart_cmd_rcv_uart.sv
// Team 8N1 UART transceiver; BAUD_DIV clocks per bit, active-low async reset.
// rx_rdy holds until clr_rx_rdy or the next start bit; tx_done holds until the next accepted trmt.
module uart_cmd_rcv_uart #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    input  logic       clr_rx_rdy
);

    localparam int BW = $clog2(BAUD_DIV) + 1;

    logic [9:0]    tx_shft;
    logic          tx_busy;
    logic [BW-1:0] tx_baud;
    logic [3:0]    tx_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft <= '1;
            tx_busy <= 1'b0;
            tx_baud <= '0;
            tx_bits <= '0;
            tx_done <= 1'b0;
        end else if (trmt && !tx_busy) begin
            tx_shft <= {1'b1, tx_data, 1'b0};
            tx_busy <= 1'b1;
            tx_baud <= '0;
            tx_bits <= '0;
            tx_done <= 1'b0;
        end else if (tx_busy) begin
            if (tx_baud == BW'(BAUD_DIV - 1)) begin
                tx_baud <= '0;
                tx_shft <= {1'b1, tx_shft[9:1]};
                tx_bits <= tx_bits + 4'd1;
                if (tx_bits == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end
            end else begin
                tx_baud <= tx_baud + BW'(1);
            end
        end
    end

    assign TX = tx_shft[0];

    logic          rx_m, rx_s;
    logic          rx_busy;
    logic [BW-1:0] rx_baud;
    logic [3:0]    rx_bits;
    logic [7:0]    rx_shft;

    // Samples land mid-bit: first countdown is half a bit, then full bits; stop bit gates rx_rdy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_busy <= 1'b0;
            rx_baud <= '0;
            rx_bits <= '0;
            rx_shft <= '0;
            rx_rdy  <= 1'b0;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
            if (clr_rx_rdy)
                rx_rdy <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s) begin
                    rx_busy <= 1'b1;
                    rx_baud <= BW'(BAUD_DIV / 2);
                    rx_bits <= '0;
                    rx_rdy  <= 1'b0;
                end
            end else if (rx_baud == '0) begin
                rx_baud <= BW'(BAUD_DIV - 1);
                rx_bits <= rx_bits + 4'd1;
                if (rx_bits == 4'd9) begin
                    rx_busy <= 1'b0;
                    rx_rdy  <= rx_s;
                end else begin
                    rx_shft <= {rx_s, rx_shft[7:1]};
                end
            end else begin
                rx_baud <= rx_baud - BW'(1);
            end
        end
    end

    assign rx_data = rx_shft;

endmodule

// File: rtl/uart_cmd_rcv.sv
// Serial command receiver: assembles cmd/data-high/data-low frames with an inter-byte timeout
// and sends single-byte responses. Optional checksum byte when UART_CMD_CHKSUM_EN is defined.
module uart_cmd_rcv
    import quad_comm_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int TMR_W       = 20,
    parameter int BAUD_DIV    = 2604
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RX,
    output logic          TX,
    uart_cmd_rcv_if.slave cif
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic       rst_n;
    logic       rx_rdy;
    logic       clr_rx_rdy;
    logic [7:0] rx_data;
    logic       tx_done;

    rcv_state_t       state;
    logic [TMR_W-1:0] tmr;
    logic [7:0]       cmd_q;
    logic [15:0]      data_q;
    logic             cmd_rdy_q;
    logic             frame_err_q;
    logic             tx_done_q;
    logic             resp_sent_q;

    assign rst_n = ~rst;
    // Every state consumes a byte the moment it appears, so the clear is just rx_rdy itself
    assign clr_rx_rdy = rx_rdy;

    uart_cmd_rcv_uart #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .TX        (TX),
        .trmt      (cif.send_resp),
        .tx_data   (cif.resp),
        .tx_done   (tx_done),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .clr_rx_rdy(clr_rx_rdy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tmr         <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (cif.clr_cmd_rdy)
                cmd_rdy_q <= 1'b0;

            // Timer and timeout handled once for all mid-frame states; an arriving byte beats the timeout
            if (state != IDLE && !rx_rdy) begin
                if (tmr == TMR_LAST) begin
                    state       <= IDLE;
                    tmr         <= '0;
                    frame_err_q <= 1'b1;
                end else begin
                    tmr <= tmr + TMR_W'(1);
                end
            end else begin
                tmr <= '0;
            end

            if (rx_rdy) begin
                case (state)
                    IDLE: begin
                        cmd_q     <= rx_data;
                        cmd_rdy_q <= 1'b0;
                        state     <= HIGH;
                    end
                    HIGH: begin
                        data_q[15:8] <= rx_data;
                        state        <= LOW;
                    end
                    LOW: begin
                        data_q[7:0] <= rx_data;
`ifdef UART_CMD_CHKSUM_EN
                        state <= CHK;
`else
                        cmd_rdy_q <= 1'b1;
                        state     <= IDLE;
`endif
                    end
`ifdef UART_CMD_CHKSUM_EN
                    CHK: begin
                        if (rx_data == frame_chksum(cmd_q, data_q))
                            cmd_rdy_q <= 1'b1;
                        else
                            frame_err_q <= 1'b1;
                        state <= IDLE;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_done_q   <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            tx_done_q   <= tx_done;
            resp_sent_q <= tx_done & ~tx_done_q;
        end
    end

    assign cif.cmd       = cmd_q;
    assign cif.data      = data_q;
    assign cif.cmd_rdy   = cmd_rdy_q;
    assign cif.frame_err = frame_err_q;
    assign cif.resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Self-checking bench for uart_cmd_rcv: directed frame table, timeout/reset/response sequences,
// and random byte streams checked against a frame-level reference model.
module tb_uart_cmd_rcv;
    import quad_comm_pkg::*;

    localparam int BAUD     = 16;
    localparam int TOUT     = 400;
    localparam int TW       = 9;
    localparam int LONG_GAP = TOUT + 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic RX  = 1'b1;
    logic TX;

    uart_cmd_rcv_if cif();

    uart_cmd_rcv #(
        .TIMEOUT_CYC(TOUT),
        .TMR_W      (TW),
        .BAUD_DIV   (BAUD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .RX (RX),
        .TX (TX),
        .cif(cif)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ferr  = 0;
    int n_rs    = 0;
    logic [7:0] tx_q[$];

    always @(posedge clk) begin
        if (cif.frame_err === 1'b1) n_ferr++;
        if (cif.resp_sent === 1'b1) n_rs++;
    end

    // Independent receiver watching TX
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (TX === 1'b0) begin
                repeat (BAUD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BAUD) @(negedge clk);
                tx_q.push_back(b);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            idle(BAUD);
        end
    endtask

    function automatic logic [7:0] model_sum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int s;
        s = (int'(a) + int'(b) + int'(c)) % 256;
        return 8'(255 - s);
    endfunction

    task automatic send_tail(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b0);
        send_byte(b1);
        send_byte(b2);
        if (FRAME_BYTES == 4) send_byte(model_sum(b0, b1, b2));
    endtask

    task automatic pulse_clr();
        cif.clr_cmd_rdy = 1'b1;
        idle(1);
        cif.clr_cmd_rdy = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  b0, b1, b2;
        logic        clr_after;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int   f0, r0, part_n, exp_ferr;
        logic exp_rdy;
        logic [7:0]  exp_cmd, b;
        logic [15:0] exp_data;
        logic [7:0]  part[4];

        tbl[0] = '{8'h05, 8'h12, 8'h34, 1'b1, 8'h05, 16'h1234};
        tbl[1] = '{8'h02, 8'hAB, 8'hCD, 1'b0, 8'h02, 16'hABCD};
        tbl[2] = '{8'h03, 8'h00, 8'h01, 1'b0, 8'h03, 16'h0001};
        tbl[3] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 8'hFF, 16'hFFFF};
        tbl[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 16'h0000};

        cif.clr_cmd_rdy = 1'b0;
        cif.send_resp   = 1'b0;
        cif.resp        = 8'h00;
        idle(4);
        rst = 1'b0;
        idle(2);
        @(negedge clk);
        chk("rst_cmd_rdy", 32'(cif.cmd_rdy), 32'd0);
        chk("rst_cmd", 32'(cif.cmd), 32'd0);
        chk("rst_data", 32'(cif.data), 32'd0);
        chk("rst_frame_err", 32'(cif.frame_err), 32'd0);
        chk("rst_tx_idle", 32'(TX), 32'd1);
        idle(1);

        // Directed frames; the first byte of every frame must knock cmd_rdy down
        for (int i = 0; i < 5; i++) begin
            send_byte(tbl[i].b0);
            @(negedge clk);
            chk("rdy_drop_first_byte", 32'(cif.cmd_rdy), 32'd0);
            idle(1);
            send_tail(tbl[i].b1, tbl[i].b2, tbl[i].b0);
            @(negedge clk);
            chk("tbl_cmd_rdy", 32'(cif.cmd_rdy), 32'd1);
            chk("tbl_cmd", 32'(cif.cmd), 32'(tbl[i].exp_cmd));
            chk("tbl_data", 32'(cif.data), 32'(tbl[i].exp_data));
            idle(3);
            if (tbl[i].clr_after) begin
                pulse_clr();
                @(negedge clk);
                chk("clr_cmd_rdy", 32'(cif.cmd_rdy), 32'd0);
                idle(1);
            end
        end
        chk("no_frame_err_directed", 32'(n_ferr), 32'd0);

        // Inter-byte timeout on a partial frame
        f0 = n_ferr;
        send_byte(8'h06);
        send_byte(8'h7F);
        @(negedge clk);
        chk("no_early_timeout", 32'(n_ferr), 32'(f0));
        chk("partial_rdy", 32'(cif.cmd_rdy), 32'd0);
        idle(TOUT + 200);
        chk("timeout_one_pulse", 32'(n_ferr), 32'(f0 + 1));
        chk("timeout_rdy", 32'(cif.cmd_rdy), 32'd0);
        send_byte(8'h01);
        send_tail(8'h00, 8'h10, 8'h01);
        @(negedge clk);
        chk("post_timeout_rdy", 32'(cif.cmd_rdy), 32'd1);
        chk("post_timeout_cmd", 32'(cif.cmd), 32'h01);
        chk("post_timeout_data", 32'(cif.data), 32'h0010);
        idle(1);

        // Response path: one byte out, a second request mid-transmission is dropped
        r0 = n_rs;
        tx_q.delete();
        cif.resp      = 8'hA5;
        cif.send_resp = 1'b1;
        idle(1);
        cif.send_resp = 1'b0;
        idle(5 * BAUD);
        cif.resp      = 8'h3C;
        cif.send_resp = 1'b1;
        idle(1);
        cif.send_resp = 1'b0;
        idle(16 * BAUD);
        chk("resp_byte_count", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) chk("resp_byte_value", 32'(tx_q[0]), 32'hA5);
        chk("resp_sent_pulses", 32'(n_rs - r0), 32'd1);

        // Reset between byte 2 and byte 3
        f0 = n_ferr;
        send_byte(8'h07);
        send_byte(8'h11);
        rst = 1'b1;
        idle(3);
        @(negedge clk);
        chk("midrst_cmd_rdy", 32'(cif.cmd_rdy), 32'd0);
        chk("midrst_cmd", 32'(cif.cmd), 32'd0);
        chk("midrst_data", 32'(cif.data), 32'd0);
        chk("midrst_tx", 32'(TX), 32'd1);
        idle(1);
        rst = 1'b0;
        idle(3);
        send_byte(8'h04);
        send_tail(8'hFF, 8'hFE, 8'h04);
        @(negedge clk);
        chk("post_rst_rdy", 32'(cif.cmd_rdy), 32'd1);
        chk("post_rst_cmd", 32'(cif.cmd), 32'h04);
        chk("post_rst_data", 32'(cif.data), 32'hFFFE);
        chk("post_rst_no_ferr", 32'(n_ferr), 32'(f0));
        idle(1);

`ifdef UART_CMD_CHKSUM_EN
        f0 = n_ferr;
        send_byte(8'h05); send_byte(8'h12); send_byte(8'h34); send_byte(8'hB4);
        @(negedge clk);
        chk("chk_good_rdy", 32'(cif.cmd_rdy), 32'd1);
        chk("chk_good_data", 32'({cif.cmd, cif.data}), 32'h051234);
        idle(1);
        send_byte(8'h05); send_byte(8'h12); send_byte(8'h34); send_byte(8'hB5);
        @(negedge clk);
        chk("chk_bad_rdy", 32'(cif.cmd_rdy), 32'd0);
        chk("chk_bad_ferr", 32'(n_ferr), 32'(f0 + 1));
        idle(1);
`endif

        // Random byte stream against a frame-level model
        pulse_clr();
        exp_rdy  = 1'b0;
        exp_cmd  = 8'h00;
        exp_data = 16'h0000;
        exp_ferr = n_ferr;
        part_n   = 0;
        for (int k = 0; k < 60; k++) begin
            if (part_n > 0 && $urandom_range(0, 7) == 0) begin
                idle(LONG_GAP);
                exp_ferr++;
                part_n = 0;
            end else begin
                idle($urandom_range(0, 40));
            end
            b = 8'($urandom);
            if (FRAME_BYTES == 4 && part_n == 3 && $urandom_range(0, 3) != 0)
                b = model_sum(part[0], part[1], part[2]);
            send_byte(b);
            part[part_n] = b;
            part_n++;
            if (part_n == 1) exp_rdy = 1'b0;
            if (part_n == FRAME_BYTES) begin
                if (FRAME_BYTES == 3 || b == model_sum(part[0], part[1], part[2])) begin
                    exp_rdy  = 1'b1;
                    exp_cmd  = part[0];
                    exp_data = {part[1], part[2]};
                end else begin
                    exp_ferr++;
                end
                part_n = 0;
            end
            @(negedge clk);
            chk("rnd_cmd_rdy", 32'(cif.cmd_rdy), 32'(exp_rdy));
            chk("rnd_frame_err_count", 32'(n_ferr), 32'(exp_ferr));
            if (exp_rdy) begin
                chk("rnd_cmd", 32'(cif.cmd), 32'(exp_cmd));
                chk("rnd_data", 32'(cif.data), 32'(exp_data));
            end
            idle(1);
            if ($urandom_range(0, 5) == 0) begin
                pulse_clr();
                exp_rdy = 1'b0;
                @(negedge clk);
                chk("rnd_clr", 32'(cif.cmd_rdy), 32'd0);
                idle(1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
